sisc_seq_ctrl: RTL and testbench

Parametrised multi-cycle control sequencer for the SISC datapath. It is the successor to the fixed 7-state controller, and adds:
- generic field widths;
- a variable-latency data-memory handshake with a watchdog timeout;
- state skipping per instruction class;
- sticky HALT/FAULT states;
- a retired-instruction counter.

It sits between the IR fields and all datapath enables (PC, IR, RF, ALU, memory, swap register).

---
 rtl/sisc_pkg.sv | 44 ++++
 rtl/sisc_br_cond.sv | 37 +++
 rtl/sisc_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sisc_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sisc_pkg
// Purpose  : Shared opcodes, state encoding and datapath mux encodings for
//            the SISC control sequencer.
// Revision : 1.0  initial release
// ============================================================================
package sisc_pkg;

   localparam int c_op_noop = 0;
   localparam int c_op_lod  = 1;
   localparam int c_op_str  = 2;
   localparam int c_op_swp  = 3;
   localparam int c_op_bra  = 4;
   localparam int c_op_brr  = 5;
   localparam int c_op_bne  = 6;
   localparam int c_op_bnr  = 7;
   localparam int c_op_alu  = 8;
   localparam int c_op_hlt  = 15;

   localparam int c_am_imm  = 8;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [1:0] c_alu_reg  = 2'b00;
   localparam logic [1:0] c_alu_imm  = 2'b01;
   localparam logic [1:0] c_alu_swp  = 2'b10;
   localparam logic [1:0] c_alu_addr = 2'b11;

   localparam logic [1:0] c_ds_rf     = 2'b00;
   localparam logic [1:0] c_ds_swp_ex = 2'b01;
   localparam logic [1:0] c_ds_swp_wb = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sisc_br_cond.sv
`default_nettype none
// ============================================================================
// Module   : sisc_br_cond
// Purpose  : Combinational branch-taken and absolute/relative target select.
// Revision : 1.0  initial release
// ============================================================================
module sisc_br_cond #(
   parameter int OPW = 4,
   parameter int MMW = 4,
   parameter int STW = 4
) (
   input  logic [OPW-1:0] i_opcode,
   input  logic [MMW-1:0] i_mm,
   input  logic [STW-1:0] i_stat,
   output logic           o_taken,
   output logic           o_br_sel
);
   import sisc_pkg::*;

   logic w_hit;

   assign w_hit = |(i_mm[STW-1:0] & i_stat);

   always_comb begin
      o_taken  = 1'b0;
      o_br_sel = 1'b0;
      case (i_opcode)
         OPW'(c_op_bra): begin o_taken = w_hit;  o_br_sel = 1'b1; end
         OPW'(c_op_brr): begin o_taken = w_hit;  o_br_sel = 1'b0; end
         OPW'(c_op_bne): begin o_taken = ~w_hit; o_br_sel = 1'b1; end
         OPW'(c_op_bnr): begin o_taken = ~w_hit; o_br_sel = 1'b0; end
         default:        begin o_taken = 1'b0;   o_br_sel = 1'b0; end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sisc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sisc_seq_ctrl
// Purpose  : Multi-cycle SISC control sequencer with memory-wait watchdog,
//            sticky HALT/FAULT and a retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module sisc_seq_ctrl #(
   parameter int OPW  = 4,
   parameter int MMW  = 4,
   parameter int STW  = 4,
   parameter int TO_W = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [OPW-1:0]  opcode,
   input  logic [MMW-1:0]  mm,
   input  logic [STW-1:0]  stat,
   input  logic            mem_ack,
   output logic            pc_rst,
   output logic            pc_write,
   output logic            pc_sel,
   output logic            br_sel,
   output logic            ir_load,
   output logic            rf_we,
   output logic            wb_sel,
   output logic            rb_sel,
   output logic [1:0]      alu_op,
   output logic [1:0]      mm_sel,
   output logic            mem_req,
   output logic            dm_we,
   output logic            swp_we,
   output logic            swp_sel,
   output logic [1:0]      data_sel,
   output logic [2:0]      state,
   output logic            halted,
   output logic            fault,
   output logic [CNTW-1:0] retired
);
   import sisc_pkg::*;

   state_t          r_state;
   state_t          w_next;
   logic [TO_W-1:0] r_wait;
   logic [CNTW-1:0] r_retired;

   logic w_is_alu, w_is_lod, w_is_str, w_is_swp, w_is_hlt, w_is_mem;
   logic w_taken, w_br_sel, w_timeout, w_retire;
   logic [1:0] w_mm_sel;

   assign w_is_alu = (opcode == OPW'(c_op_alu));
   assign w_is_lod = (opcode == OPW'(c_op_lod));
   assign w_is_str = (opcode == OPW'(c_op_str));
   assign w_is_swp = (opcode == OPW'(c_op_swp));
   assign w_is_hlt = (opcode == OPW'(c_op_hlt));
   assign w_is_mem = w_is_lod | w_is_str | w_is_swp;

   assign w_timeout = (r_wait == {TO_W{1'b1}});
   assign w_mm_sel  = mm[MMW-1] ? 2'b00 : (mm[0] ? 2'b10 : 2'b01);

   sisc_br_cond #(.OPW(OPW), .MMW(MMW), .STW(STW)) u_br_cond (
      .i_opcode (opcode),
      .i_mm     (mm),
      .i_stat   (stat),
      .o_taken  (w_taken),
      .o_br_sel (w_br_sel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_RESET;
      else     r_state <= w_next;
   end

   // Retire on every return to FETCH after real work, and on halting.
   assign w_retire = ((w_next == S_FETCH) &&
                      (r_state == S_DECODE || r_state == S_MEM || r_state == S_WB)) ||
                     ((w_next == S_HALT) && (r_state != S_HALT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait    <= '0;
         r_retired <= '0;
      end else begin
         if (r_state != S_MEM)
            r_wait <= '0;
         else if (!mem_ack && !w_timeout)
            r_wait <= r_wait + 1'b1;
         if (w_retire)
            r_retired <= r_retired + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RESET:  if (run) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (w_is_hlt)                 w_next = S_HALT;
            else if (w_is_alu || w_is_mem) w_next = S_EXEC;
            else                          w_next = S_FETCH;
         end
         S_EXEC:   w_next = w_is_alu ? S_WB : (w_is_mem ? S_MEM : S_FETCH);
         S_MEM: begin
            // An ack in the final allowed wait cycle takes priority over the watchdog.
            if (mem_ack)        w_next = w_is_str ? S_FETCH : S_WB;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_FAULT;
      endcase
   end

   always_comb begin
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      ir_load  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      rb_sel   = 1'b0;
      alu_op   = c_alu_reg;
      mm_sel   = 2'b00;
      mem_req  = 1'b0;
      dm_we    = 1'b0;
      swp_we   = 1'b0;
      swp_sel  = 1'b0;
      data_sel = c_ds_rf;
      halted   = 1'b0;
      fault    = 1'b0;
      case (r_state)
         S_RESET: pc_rst = 1'b1;
         S_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         S_DECODE: begin
            if (w_is_alu)      rb_sel = (mm != '0);
            else if (w_is_mem) rb_sel = 1'b1;
            if (w_taken) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               br_sel   = w_br_sel;
            end
         end
         S_EXEC: begin
            if (w_is_alu) begin
               alu_op = (mm == MMW'(c_am_imm)) ? c_alu_imm : c_alu_reg;
            end else if (w_is_lod || w_is_str) begin
               alu_op = c_alu_addr;
               mm_sel = w_mm_sel;
            end else if (w_is_swp) begin
               alu_op   = c_alu_swp;
               swp_we   = 1'b1;
               data_sel = c_ds_swp_ex;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (w_is_lod || w_is_str) mm_sel = w_mm_sel;
            if (w_is_str) dm_we = 1'b1;
            if (w_is_lod) begin
               wb_sel = 1'b1;
               rf_we  = mem_ack;
            end
         end
         S_WB: begin
            if (w_is_alu) begin
               rf_we = 1'b1;
            end else if (w_is_lod && mm[0]) begin
               rf_we   = 1'b1;
               swp_sel = 1'b1;
            end else if (w_is_swp) begin
               rf_we    = 1'b1;
               swp_sel  = 1'b1;
               data_sel = c_ds_swp_wb;
            end
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: pc_rst = 1'b0;
      endcase
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_sisc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sisc_seq_ctrl
// Purpose  : Randomised scoreboard bench for sisc_seq_ctrl (per-instruction
//            summaries predicted from opcode class and memory wait count).
// Revision : 1.0  initial release
// ============================================================================
module tb_sisc_seq_ctrl;
   localparam int TO_W   = 2;
   localparam int CNTW   = 4;
   localparam int NMEMTO = 1 << TO_W;

   logic clk = 1'b0;
   logic rst, run, mem_ack;
   logic [3:0] opcode, mm, stat;
   logic pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, rb_sel;
   logic [1:0] alu_op, mm_sel, data_sel;
   logic mem_req, dm_we, swp_we, swp_sel, halted, fault;
   logic [2:0] state;
   logic [CNTW-1:0] retired;

   always #5 clk = ~clk;

   sisc_seq_ctrl #(.OPW(4), .MMW(4), .STW(4), .TO_W(TO_W), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mm(mm), .stat(stat),
      .mem_ack(mem_ack), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
      .br_sel(br_sel), .ir_load(ir_load), .rf_we(rf_we), .wb_sel(wb_sel),
      .rb_sel(rb_sel), .alu_op(alu_op), .mm_sel(mm_sel), .mem_req(mem_req),
      .dm_we(dm_we), .swp_we(swp_we), .swp_sel(swp_sel), .data_sel(data_sel),
      .state(state), .halted(halted), .fault(fault), .retired(retired)
   );

   // Per-instruction summary: activity counts plus values seen in each phase.
   typedef struct {
      int cycles, req, dmwe, rfwe, wbsel, swpwe, swpsel, irl, pcrst, hf;
      int pcw, psel, dbr, drb, exalu, exmm, exdata, memmm, wbdata, ret, fin;
   } txn_t;

   txn_t q[$];
   int total = 0;
   int bad   = 0;
   int model_ret = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic txn_t model(input int op, input int m, input int s,
                                  input int w, input bit to, input int ret_in);
      txn_t t;
      int nm;
      bit ack, wb, tk;
      t = '{default:0};
      t.cycles = 2; t.irl = 1; t.pcw = 1; t.fin = 1;
      t.ret = (ret_in + 1) % (1 << CNTW);
      if (op == 15) begin
         t.fin = 6;
      end else if (op >= 4 && op <= 7) begin
         tk = (op <= 5) ? ((m & s) != 0) : ((m & s) == 0);
         t.pcw  = 1 + int'(tk);
         t.psel = int'(tk);
         t.dbr  = int'(tk && (op == 4 || op == 6));
      end else if (op == 8) begin
         t.cycles = 4; t.drb = int'(m != 0); t.rfwe = 1;
         t.exalu  = (m == 8) ? 1 : 0;
      end else if (op >= 1 && op <= 3) begin
         nm  = to ? NMEMTO : w + 1;
         ack = !to;
         wb  = ack && (op != 2);
         t.cycles = 3 + nm + int'(wb);
         t.req = nm; t.drb = 1;
         if (to) begin t.fin = 7; t.ret = ret_in; end
         if (op == 3) begin
            t.exalu = 2; t.swpwe = 1; t.exdata = 1;
            t.swpsel = int'(wb); t.rfwe = int'(wb); t.wbdata = wb ? 2 : 0;
         end else begin
            t.exalu = 3;
            t.exmm  = (m >= 8) ? 0 : ((m % 2 == 1) ? 2 : 1);
            t.memmm = t.exmm;
            if (op == 2) t.dmwe = nm;
            else begin
               t.wbsel  = nm;
               t.rfwe   = int'(ack) + int'(wb && (m % 2 == 1));
               t.swpsel = int'(wb && (m % 2 == 1));
            end
         end
      end
      return t;
   endfunction

   // Drives one instruction starting in its FETCH cycle, timed by the model.
   task automatic issue(input int op, input int m, input int s, input int w, input bit to);
      txn_t t;
      int nm;
      t = model(op, m, s, w, to, model_ret);
      model_ret = t.ret;
      q.push_back(t);
      nm = to ? NMEMTO : w + 1;
      opcode = op[3:0]; mm = m[3:0]; stat = s[3:0];
      for (int k = 0; k < t.cycles; k++) begin
         if (op >= 1 && op <= 3 && k >= 3 && k < 3 + nm) mem_ack = !to && (k == 3 + w);
         else mem_ack = 1'($urandom_range(0, 1));
         run = (op == 15) ? 1'b1 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
   endtask

   task automatic rand_instr();
      int op, m;
      op = $urandom_range(0, 14);
      m  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) m = ($urandom_range(0, 1) == 1) ? 8 : 0;
      issue(op, m, $urandom_range(0, 15), $urandom_range(0, NMEMTO - 1), 1'b0);
   endtask

   task automatic hold_check(input int es, input int n);
      for (int i = 0; i < n; i++) begin
         run = 1'b1; mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("sticky_state", int'(state), es);
         chk("sticky_halted", int'(halted), int'(es == 6));
         chk("sticky_fault", int'(fault), int'(es == 7));
         chk("sticky_ir_load", int'(ir_load), 0);
         chk("sticky_retired", int'(retired), model_ret);
         @(posedge clk); #1;
      end
   endtask

   task automatic async_reset_check();
      #3 rst = 1'b1;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_retired", int'(retired), 0);
      chk("arst_mem_req", int'(mem_req), 0);
      chk("arst_dm_we", int'(dm_we), 0);
      chk("arst_flags", int'({halted, fault}), 0);
      chk("arst_pc_rst", int'(pc_rst), 1);
      model_ret = 0;
      @(posedge clk); #1 rst = 1'b0; run = 1'b1;
      @(posedge clk); #1;
      chk("arst_refetch", int'(state), 1);
   endtask

   // Monitor: an instruction window opens at FETCH and closes at the next
   // FETCH, HALT or FAULT, where the summary is compared with the queue head.
   initial begin
      txn_t o, e;
      bit open;
      open = 1'b0;
      o = '{default:0};
      forever begin
         @(negedge clk);
         if (rst) begin
            open = 1'b0;
         end else begin
            if (open && (state == 3'd1 || state == 3'd6 || state == 3'd7)) begin
               open = 1'b0;
               o.ret = int'(retired); o.fin = int'(state);
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL sb_underflow: got completed instruction, expected none (t=%0t)", $time);
               end else begin
                  e = q.pop_front();
                  chk("cycles", o.cycles, e.cycles);   chk("mem_req_n", o.req, e.req);
                  chk("dm_we_n", o.dmwe, e.dmwe);      chk("rf_we_n", o.rfwe, e.rfwe);
                  chk("wb_sel_n", o.wbsel, e.wbsel);   chk("swp_we_n", o.swpwe, e.swpwe);
                  chk("swp_sel_n", o.swpsel, e.swpsel); chk("ir_load_n", o.irl, e.irl);
                  chk("pc_rst_n", o.pcrst, e.pcrst);   chk("halt_fault_n", o.hf, e.hf);
                  chk("pc_write_n", o.pcw, e.pcw);     chk("pc_sel_n", o.psel, e.psel);
                  chk("dec_br_sel", o.dbr, e.dbr);     chk("dec_rb_sel", o.drb, e.drb);
                  chk("ex_alu_op", o.exalu, e.exalu);  chk("ex_mm_sel", o.exmm, e.exmm);
                  chk("ex_data_sel", o.exdata, e.exdata); chk("mem_mm_sel", o.memmm, e.memmm);
                  chk("wb_data_sel", o.wbdata, e.wbdata); chk("retired", o.ret, e.ret);
                  chk("end_state", o.fin, e.fin);
               end
            end
            if (state == 3'd1) begin
               open = 1'b1;
               o = '{default:0};
            end
            if (open) begin
               o.cycles++;
               o.req   += int'(mem_req);  o.dmwe   += int'(dm_we);
               o.rfwe  += int'(rf_we);    o.wbsel  += int'(wb_sel);
               o.swpwe += int'(swp_we);   o.swpsel += int'(swp_sel);
               o.irl   += int'(ir_load);  o.pcrst  += int'(pc_rst);
               o.hf    += int'(halted) + int'(fault);
               o.pcw   += int'(pc_write); o.psel   += int'(pc_sel);
               case (state)
                  3'd2: begin o.dbr = int'(br_sel); o.drb = int'(rb_sel); end
                  3'd3: begin o.exalu = int'(alu_op); o.exmm = int'(mm_sel); o.exdata = int'(data_sel); end
                  3'd4: o.memmm = int'(mm_sel);
                  3'd5: o.wbdata = int'(data_sel);
                  default: ;
               endcase
               if (o.cycles > 40) begin
                  total++; bad++;
                  $display("FAIL instr_watchdog: got %0d cycles, expected completion within 40", o.cycles);
                  open = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; run = 1'b0; opcode = '0; mm = '0; stat = '0; mem_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_state", int'(state), 0);
         chk("reset_pc_rst", int'(pc_rst), 1);
         chk("reset_retired", int'(retired), 0);
         chk("reset_other_outs", int'({pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel,
             rb_sel, alu_op, mm_sel, mem_req, dm_we, swp_we, swp_sel, data_sel, halted, fault}), 0);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("run_low_state", int'(state), 0);
      end
      run = 1'b1;
      @(posedge clk); #1;
      chk("run_fetch", int'(state), 1);
      model_ret = 0;

      issue(8, 8, 0, 0, 1'b0);
      issue(4, 2, 2, 0, 1'b0);
      issue(7, 2, 2, 0, 1'b0);
      issue(1, 0, 0, 3, 1'b0);
      issue(2, 5, 0, 0, 1'b0);
      issue(3, 1, 0, 2, 1'b0);
      issue(1, 9, 0, 1, 1'b0);
      issue(8, 0, 0, 0, 1'b0);
      repeat (30) rand_instr();
      issue(15, $urandom_range(0, 15), 0, 0, 1'b0);
      hold_check(6, 4);

      async_reset_check();
      repeat (20) rand_instr();
      issue($urandom_range(1, 3), $urandom_range(0, 15), 0, 0, 1'b1);
      hold_check(7, 4);

      async_reset_check();
      repeat (5) rand_instr();
      opcode = 4'd2; mm = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
         mem_ack = (k >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      chk("midmem_state", int'(state), 4);
      chk("midmem_mem_req", int'(mem_req), 1);
      chk("midmem_dm_we", int'(dm_we), 1);
      async_reset_check();

      @(negedge clk);
      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
